// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constant helpers for the sequential convolver
//
// Purpose: FSM state encoding and elaboration-time width helpers used by
//          conv_seq_engine and conv_mac.
// Contents: state_e (S_IDLE/S_MAC/S_EMIT), clog2, clog2_min1, imin, imax, acc_width.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Index widths must be at least one bit even when only one value exists.
  function automatic int clog2_min1(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // At most min(n,m) products are summed per output; the extra bit keeps the
  // accumulator a signed quantity for both operand modes.
  function automatic int acc_width(input int dw, input int n, input int m);
    return 2 * dw + clog2(imin(n, m)) + 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - registered multiply-accumulate for the sequential convolver
//
// Purpose: acc <= clr ? 0 : en ? acc + a*b : acc, operands sign- or zero-extended per SIGNED.
// Ports:
//   clk        in  clock
//   rst_n      in  synchronous reset, active low (clears acc)
//   clr_i      in  clear accumulator (priority over en_i)
//   en_i       in  accumulate one product
//   a_i, b_i   in  [DW-1:0] operands
//   acc_nxt_o  out [ACC_W-1:0] acc + a*b, the value the next enabled edge will store
module conv_mac #(
  parameter int DW     = 16,
  parameter int ACC_W  = 33,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [ACC_W-1:0] acc_nxt_o
);

  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q;

  // Extending straight to ACC_W keeps the low ACC_W product bits exact, since
  // every true product and partial sum fits in ACC_W signed bits.
  assign a_ext = (SIGNED != 0) ? {{(ACC_W-DW){a_i[DW-1]}}, a_i} : {{(ACC_W-DW){1'b0}}, a_i};
  assign b_ext = (SIGNED != 0) ? {{(ACC_W-DW){b_i[DW-1]}}, b_i} : {{(ACC_W-DW){1'b0}}, b_i};
  assign prod      = a_ext * b_ext;
  assign acc_nxt_o = acc_q + prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_nxt_o;
    end
  end

endmodule

// File: rtl/conv_seq_engine.sv
// rtl/conv_seq_engine.sv - sequential full linear convolver with one shared MAC
//
// Purpose: captures A (N elems) and B (M elems) on start, computes c[0..N+M-2] one
//          product per cycle, streams each c[i] out over a valid/ready port.
// Config macro: CONV_SAT_EN - saturate out_data to the OW range instead of truncating.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin a run (honoured only when idle)
//   arr_a, arr_b        operand vectors
//   busy                not idle
//   out_valid/out_ready result handshake
//   out_data, out_idx   result c[out_idx]
//   out_last            out_idx is the final index
//   done                one-cycle pulse after the final result is accepted
module conv_seq_engine
  import conv_pkg::*;
#(
  parameter int N      = 3,
  parameter int M      = 2,
  parameter int DW     = 16,
  parameter int OW     = 32,
  parameter int SIGNED = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N-1:0][DW-1:0]          arr_a,
  input  logic [M-1:0][DW-1:0]          arr_b,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OW-1:0]                 out_data,
  output logic [clog2_min1(N+M-1)-1:0]  out_idx,
  output logic                          out_last,
  output logic                          done
);

  localparam int IW     = clog2_min1(N + M - 1);
  localparam int JW     = clog2_min1(N);
  localparam int ACC_W  = acc_width(DW, N, M);
  localparam int LAST_I = N + M - 2;

  state_e               state_q, state_d;
  logic [IW-1:0]        i_q, i_d;
  logic [JW-1:0]        j_q, j_d;
  logic [N-1:0][DW-1:0] a_q, a_d;
  logic [M-1:0][DW-1:0] b_q, b_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [OW-1:0]        out_data_q, out_data_d;
  logic [IW-1:0]        out_idx_q, out_idx_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic                 mac_clr, mac_en;
  logic [DW-1:0]        a_sel, b_sel;
  logic [ACC_W-1:0]     acc_nxt;
  logic [OW-1:0]        narrow;
  int                   i_int, j_int, bidx;

  assign i_int = int'(i_q);
  assign j_int = int'(j_q);
  assign bidx  = i_int - j_int;

  // Explicit muxes keep indexing in range for any N/M, including N=1 or M=1.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < N; k++) if (j_int == k) a_sel = a_q[k];
    for (int k = 0; k < M; k++) if (bidx == k) b_sel = b_q[k];
  end

  conv_mac #(.DW(DW), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (mac_clr),
    .en_i      (mac_en),
    .a_i       (a_sel),
    .b_i       (b_sel),
    .acc_nxt_o (acc_nxt)
  );

  // Unsigned accumulations never set the top bit, so sign extension is correct for both modes.
  if (OW > ACC_W) begin : g_ext
    assign narrow = {{(OW-ACC_W){acc_nxt[ACC_W-1]}}, acc_nxt};
  end else if (OW == ACC_W) begin : g_same
    assign narrow = acc_nxt;
  end else begin : g_narrow
`ifdef CONV_SAT_EN
    if (SIGNED != 0) begin : g_sat_s
      logic ovf_pos, ovf_neg;
      assign ovf_pos = !acc_nxt[ACC_W-1] && (acc_nxt[ACC_W-2:OW-1] != '0);
      assign ovf_neg =  acc_nxt[ACC_W-1] && (acc_nxt[ACC_W-2:OW-1] != '1);
      assign narrow  = ovf_pos ? {1'b0, {(OW-1){1'b1}}} :
                       ovf_neg ? {1'b1, {(OW-1){1'b0}}} : acc_nxt[OW-1:0];
    end else begin : g_sat_u
      assign narrow = (acc_nxt[ACC_W-1:OW] != '0) ? '1 : acc_nxt[OW-1:0];
    end
`else
    logic hi_unused;
    assign hi_unused = ^acc_nxt[ACC_W-1:OW];
    assign narrow    = acc_nxt[OW-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = arr_a;
          b_d     = arr_b;
          i_d     = '0;
          j_d     = '0;
          mac_clr = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (j_int == imin(i_int, N - 1)) begin
          // Register the final sum directly so out_data appears with out_valid.
          out_valid_d = 1'b1;
          out_data_d  = narrow;
          out_idx_d   = i_q;
          out_last_d  = (i_int == LAST_I);
          state_d     = S_EMIT;
        end else begin
          j_d = JW'(j_int + 1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          mac_clr     = 1'b1;
          if (i_int == LAST_I) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            i_d     = IW'(i_int + 1);
            j_d     = JW'(imax(0, i_int + 2 - M));
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule
